// File: rtl/btc_pkg.sv
// btc_pkg: shared constants, dispatcher state encoding and bus word-slice helpers.
package btc_pkg;

    localparam logic [31:0] SHA_PAD_WORD  = 32'h80000000;
    localparam logic [31:0] HDR2_LEN_WORD = 32'h00000280;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } disp_state_e;

    function automatic logic [31:0] word256(input logic [255:0] bus, input int unsigned i);
        return bus[255-32*i -: 32];
    endfunction

    function automatic logic [31:0] word512(input logic [511:0] bus, input int unsigned i);
        return bus[511-32*i -: 32];
    endfunction

endpackage

// File: rtl/btc_nonce_dispatcher.sv
// btc_nonce_dispatcher: sweeps a nonce range, issuing one padded header chunk 2 plus midstate per cycle.
module btc_nonce_dispatcher
    import btc_pkg::*;
#(
    parameter int unsigned NONCE_STEP = 1,
    parameter int unsigned CNT_W      = 48
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             rst,
    input  logic             work_valid_i,
    output logic             work_ready_o,
    input  logic [255:0]     midstate_i,
    input  logic [31:0]      merkle_tail_i,
    input  logic [31:0]      ntime_i,
    input  logic [31:0]      nbits_i,
    input  logic [31:0]      nonce_start_i,
    input  logic [31:0]      nonce_end_i,
    input  logic             abort_i,
    input  logic             stall_i,
    output logic             valid_o,
    output logic [255:0]     init_o,
    output logic [511:0]     chunk_o,
    output logic [31:0]      nonce_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] issued_o
);

    disp_state_e      state_q, state_d;
    logic [31:0]      cnt_q, cnt_d, tail_q, tail_d, ntime_q, ntime_d, nbits_q, nbits_d, end_q, end_d;
    logic [255:0]     mid_q, mid_d, init_q, init_d;
    logic [511:0]     chunk_q, chunk_d;
    logic [31:0]      nonce_q, nonce_d;
    logic             valid_q, valid_d, done_q, done_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [32:0]      cnt_nxt;
    logic             last;

    // 33-bit compare keeps a sweep ending near 2^32 from wrapping back to nonce 0
    assign cnt_nxt = {1'b0, cnt_q} + 33'(NONCE_STEP);
    assign last    = (cnt_nxt > {1'b0, end_q}) || (cnt_q == end_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tail_d   = tail_q;
        ntime_d  = ntime_q;
        nbits_d  = nbits_q;
        end_d    = end_q;
        mid_d    = mid_q;
        init_d   = init_q;
        chunk_d  = chunk_q;
        nonce_d  = nonce_q;
        issued_d = issued_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: if (work_valid_i) begin
                mid_d   = midstate_i;
                tail_d  = merkle_tail_i;
                ntime_d = ntime_i;
                nbits_d = nbits_i;
                end_d   = nonce_end_i;
                cnt_d   = nonce_start_i;
                state_d = RUN;
            end
            RUN: if (abort_i) begin
                state_d = IDLE;
            end else if (!stall_i) begin
                valid_d  = 1'b1;
                nonce_d  = cnt_q;
                init_d   = mid_q;
                chunk_d  = {tail_q, ntime_q, nbits_q, cnt_q, SHA_PAD_WORD, 320'b0, HDR2_LEN_WORD};
                issued_d = issued_q + CNT_W'(1);
                state_d  = last ? DONE : RUN;
                cnt_d    = last ? cnt_q : cnt_nxt[31:0];
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            state_d  = IDLE;
            cnt_d    = '0;
            tail_d   = '0;
            ntime_d  = '0;
            nbits_d  = '0;
            end_d    = '0;
            mid_d    = '0;
            init_d   = '0;
            chunk_d  = '0;
            nonce_d  = '0;
            issued_d = '0;
            valid_d  = 1'b0;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            tail_q   <= '0;
            ntime_q  <= '0;
            nbits_q  <= '0;
            end_q    <= '0;
            mid_q    <= '0;
            init_q   <= '0;
            chunk_q  <= '0;
            nonce_q  <= '0;
            issued_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tail_q   <= tail_d;
            ntime_q  <= ntime_d;
            nbits_q  <= nbits_d;
            end_q    <= end_d;
            mid_q    <= mid_d;
            init_q   <= init_d;
            chunk_q  <= chunk_d;
            nonce_q  <= nonce_d;
            issued_q <= issued_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    assign work_ready_o = (state_q == IDLE);
    assign busy_o       = (state_q != IDLE);
    assign valid_o      = valid_q;
    assign done_o       = done_q;
    assign nonce_o      = nonce_q;
    assign init_o       = init_q;
    assign chunk_o      = chunk_q;
    assign issued_o     = issued_q;

endmodule

// File: tb/tb_btc_nonce_dispatcher.sv
// tb_btc_nonce_dispatcher: table-driven sweeps against a nonce scoreboard, plus abort and reset sequences.
module tb_btc_nonce_dispatcher;
    import btc_pkg::*;

    logic         clk = 1'b0, arst = 1'b1, rst = 1'b0;
    logic         work_valid = 1'b0, abort = 1'b0, stall = 1'b0, sel = 1'b0;
    logic [255:0] mid = '0;
    logic [31:0]  tail = '0, ntime = '0, nbits = '0, nstart = '0, nend = '0;

    logic         rdy_a [2], v_a [2], bsy_a [2], dn_a [2];
    logic [31:0]  n_a [2];
    logic [255:0] i_a [2];
    logic [511:0] c_a [2];
    logic [47:0]  is_a [2];

    logic         rdy, v, bsy, dn;
    logic [31:0]  nn;
    logic [255:0] in;
    logic [511:0] ch;
    logic [47:0]  is;
    assign rdy = rdy_a[sel];
    assign v   = v_a[sel];
    assign bsy = bsy_a[sel];
    assign dn  = dn_a[sel];
    assign nn  = n_a[sel];
    assign in  = i_a[sel];
    assign ch  = c_a[sel];
    assign is  = is_a[sel];

    always #5 clk = ~clk;

    btc_nonce_dispatcher #(.NONCE_STEP(1), .CNT_W(48)) dut1 (
        .clk(clk), .arst(arst), .rst(rst), .work_valid_i(work_valid && !sel), .work_ready_o(rdy_a[0]),
        .midstate_i(mid), .merkle_tail_i(tail), .ntime_i(ntime), .nbits_i(nbits),
        .nonce_start_i(nstart), .nonce_end_i(nend), .abort_i(abort), .stall_i(stall),
        .valid_o(v_a[0]), .init_o(i_a[0]), .chunk_o(c_a[0]), .nonce_o(n_a[0]),
        .busy_o(bsy_a[0]), .done_o(dn_a[0]), .issued_o(is_a[0])
    );

    btc_nonce_dispatcher #(.NONCE_STEP(3), .CNT_W(48)) dut3 (
        .clk(clk), .arst(arst), .rst(rst), .work_valid_i(work_valid && sel), .work_ready_o(rdy_a[1]),
        .midstate_i(mid), .merkle_tail_i(tail), .ntime_i(ntime), .nbits_i(nbits),
        .nonce_start_i(nstart), .nonce_end_i(nend), .abort_i(abort), .stall_i(stall),
        .valid_o(v_a[1]), .init_o(i_a[1]), .chunk_o(c_a[1]), .nonce_o(n_a[1]),
        .busy_o(bsy_a[1]), .done_o(dn_a[1]), .issued_o(is_a[1])
    );

    typedef struct {
        logic        s;
        logic [31:0] st;
        logic [31:0] en;
        int          sa;
        int          sl;
        int          n;
    } vec_t;

    vec_t        vt [6];
    int          passed = 0, total = 0;
    logic [31:0] q [$];
    logic [47:0] exp_iss [2] = '{48'd0, 48'd0};

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive_work(input logic s, input logic [31:0] st, input logic [31:0] en);
        @(negedge clk);
        sel = s;
        mid = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        tail = $urandom;
        ntime = $urandom;
        nbits = $urandom;
        nstart = st;
        nend = en;
        work_valid = 1'b1;
        @(negedge clk);
        work_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t t);
        logic [31:0]  n, e, last_n;
        logic [511:0] exp_ch;
        int           step, issues, gaps, stl;
        logic         prev, got_done;
        step = t.s ? 3 : 1;
        n = t.st;
        q.delete();
        for (int k = 0; k < 64; k++) begin
            q.push_back(n);
            if (({1'b0, n} + 33'(step) > {1'b0, t.en}) || n == t.en) break;
            n = n + 32'(step);
        end
        chk("issue_count_model", 512'(q.size()), 512'(t.n));
        exp_iss[t.s] = exp_iss[t.s] + 48'(t.n);
        drive_work(t.s, t.st, t.en);
        chk("busy_after_accept", 512'(bsy), 512'(1));
        chk("ready_low_in_run", 512'(rdy), 512'(0));
        chk("no_valid_at_e0", 512'(v), 512'(0));
        issues = 0; gaps = 0; stl = 0; prev = 1'b0; got_done = 1'b0; last_n = '0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (dn) begin
                got_done = 1'b1;
                chk("done_follows_valid", 512'(prev), 512'(1));
                chk("valid_low_at_done", 512'(v), 512'(0));
                chk("scoreboard_empty", 512'(q.size()), 512'(0));
                chk("issued_count", 512'(is), 512'(exp_iss[t.s]));
                chk("nonce_holds", 512'(nn), 512'(last_n));
                break;
            end
            if (v) begin
                if (q.size() == 0) chk("unexpected_issue", 512'(nn), 512'(0) - 512'(1));
                else begin
                    e = q.pop_front();
                    exp_ch = {tail, ntime, nbits, e, 32'h80000000, 320'b0, 32'h00000280};
                    chk("nonce", 512'(nn), 512'(e));
                    chk("chunk", ch, exp_ch);
                    chk("chunk_w3", 512'(word512(ch, 3)), 512'(e));
                    chk("init", 512'(in), 512'(mid));
                    last_n = e;
                end
                issues++;
            end else if (issues > 0) gaps++;
            prev = v;
            if (t.sl > 0 && issues == t.sa && stl < t.sl) begin
                stall = 1'b1;
                stl++;
            end else stall = 1'b0;
        end
        stall = 1'b0;
        chk("done_seen", 512'(got_done), 512'(1));
        chk("stall_gap_cycles", 512'(gaps), 512'(t.sl));
        @(negedge clk);
        chk("done_one_cycle", 512'(dn), 512'(0));
        chk("ready_after_done", 512'(rdy), 512'(1));
    endtask

    initial begin
        vt[0] = '{1'b0, 32'h10,       32'h13,       0, 0, 4};
        vt[1] = '{1'b0, 32'h0,        32'h7,        2, 3, 8};
        vt[2] = '{1'b0, 32'hFFFFFFFE, 32'hFFFFFFFF, 0, 0, 2};
        vt[3] = '{1'b0, 32'h20,       32'h10,       0, 0, 1};
        vt[4] = '{1'b1, 32'h1,        32'hA,        0, 0, 4};
        vt[5] = '{1'b1, 32'h1,        32'h9,        0, 0, 3};

        repeat (2) @(negedge clk);
        chk("rst_valid", 512'(v), 512'(0));
        chk("rst_ready", 512'(rdy), 512'(1));
        chk("rst_busy", 512'(bsy), 512'(0));
        chk("rst_done", 512'(dn), 512'(0));
        chk("rst_nonce", 512'(nn), 512'(0));
        chk("rst_init", 512'(in), 512'(0));
        chk("rst_chunk", ch, 512'(0));
        chk("rst_issued", 512'(is), 512'(0));
        arst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vt[i]);

        // abort on the third issue; a work offer mid-run must be ignored
        drive_work(1'b0, 32'd0, 32'd99);
        nstart = 32'h500;
        work_valid = 1'b1;
        @(negedge clk);
        work_valid = 1'b0;
        chk("abort_issue0_valid", 512'(v), 512'(1));
        chk("abort_issue0", 512'(nn), 512'(0));
        @(negedge clk);
        chk("abort_issue1", 512'(nn), 512'(1));
        @(negedge clk);
        chk("abort_issue2", 512'(nn), 512'(2));
        abort = 1'b1;
        stall = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        stall = 1'b0;
        chk("abort_valid", 512'(v), 512'(0));
        chk("abort_ready", 512'(rdy), 512'(1));
        chk("abort_no_done", 512'(dn), 512'(0));
        exp_iss[0] = exp_iss[0] + 48'd3;
        chk("abort_issued", 512'(is), 512'(exp_iss[0]));
        repeat (4) begin
            @(negedge clk);
            chk("abort_quiet", 512'({v, dn}), 512'(0));
        end
        run_vec('{1'b0, 32'h5, 32'h6, 0, 0, 2});

        // asynchronous reset mid-run clears outputs without waiting for a clock
        drive_work(1'b0, 32'd0, 32'd99);
        repeat (2) @(negedge clk);
        arst = 1'b1;
        #1;
        chk("arst_valid", 512'(v), 512'(0));
        chk("arst_nonce", 512'(nn), 512'(0));
        chk("arst_chunk", ch, 512'(0));
        chk("arst_init", 512'(in), 512'(0));
        chk("arst_issued", 512'(is), 512'(0));
        chk("arst_ready", 512'(rdy), 512'(1));
        @(negedge clk);
        arst = 1'b0;
        exp_iss[0] = '0;
        exp_iss[1] = '0;

        drive_work(1'b0, 32'h40, 32'h4F);
        @(negedge clk);
        chk("srst_pre_valid", 512'(v), 512'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("srst_valid", 512'(v), 512'(0));
        chk("srst_issued", 512'(is), 512'(0));
        chk("srst_nonce", 512'(nn), 512'(0));
        chk("srst_ready", 512'(rdy), 512'(1));
        run_vec('{1'b0, 32'h30, 32'h31, 0, 0, 2});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
